// File: rtl/merge_leaf_refill_scheduler.sv
// Round-robin scheduler for line bursts that refill the leaf FIFOs of a merge tree.
// A leaf is requested only when its FIFO has room for the whole burst; completion waits for every line to return.
//
// state | meaning
// IDLE  | waiting for i_start
// PICK  | searching leaves from rr_ptr for one with room and lines left
// REQ   | request presented, held stable until i_req_ready
// DRAIN | all lines requested, waiting for outstanding to reach 0
// DONE  | one-cycle o_done pulse
module merge_leaf_refill_scheduler #(
   parameter int NUM_LEAVES = 8,
   parameter int LEAF_W     = 3,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5,
   parameter int BURST_LEN  = 4,
   parameter int ADDR_W     = 32,
   parameter int LINES_W    = 16,
   parameter int OUT_W      = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_W-1:0]     i_run_base,
   input  logic [LINES_W-1:0]    i_run_lines,
   output logic                  o_req_valid,
   output logic [ADDR_W-1:0]     o_req_addr,
   output logic [2:0]            o_req_len,
   output logic [LEAF_W-1:0]     o_req_leaf,
   input  logic                  i_req_ready,
   input  logic                  i_rsp_valid,
   input  logic [NUM_LEAVES-1:0] i_leaf_deq,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   typedef enum logic [2:0] {S_IDLE, S_PICK, S_REQ, S_DRAIN, S_DONE} state_t;

   state_t state, state_nxt;

   logic [LINES_W-1:0] remaining [NUM_LEAVES];
   logic [ADDR_W-1:0]  next_addr [NUM_LEAVES];
   logic [CNT_W-1:0]   reserved  [NUM_LEAVES];
   logic [CNT_W-1:0]   res_nxt   [NUM_LEAVES];
   logic [LINES_W-1:0] want      [NUM_LEAVES];
   logic [LINES_W-1:0] room      [NUM_LEAVES];
   logic [NUM_LEAVES-1:0] elig;
   logic [OUT_W-1:0]   outstanding, out_sum, out_nxt;
   logic [LEAF_W-1:0]  rr_ptr, idx, pick_leaf;
   logic [2:0]         pick_len;
   logic [CNT_W-1:0]   res_sum;
   logic               found, any_rem, rem_left, hs, start_acc, err_set;

   assign hs        = (state == S_REQ) && i_req_ready;
   assign start_acc = (state == S_IDLE) && i_start;

   // Eligibility: lines left and enough uncommitted FIFO space for the next burst
   always_comb begin
      any_rem  = 1'b0;
      rem_left = 1'b0;
      for (int k = 0; k < NUM_LEAVES; k++) begin
         want[k] = (remaining[k] > LINES_W'(BURST_LEN)) ? LINES_W'(BURST_LEN) : remaining[k];
         room[k] = LINES_W'(FIFO_DEPTH) - LINES_W'(reserved[k]);
         elig[k] = (remaining[k] != '0) && (LINES_W'(reserved[k]) <= LINES_W'(FIFO_DEPTH))
                   && (room[k] >= want[k]);
         any_rem = any_rem | (remaining[k] != '0);
         if (LEAF_W'(k) == o_req_leaf)
            rem_left = rem_left | (remaining[k] != LINES_W'(o_req_len));
         else
            rem_left = rem_left | (remaining[k] != '0);
      end
   end

   always_comb begin
      found     = 1'b0;
      pick_leaf = '0;
      idx       = '0;
      for (int i = 0; i < NUM_LEAVES; i++) begin
         idx = rr_ptr + LEAF_W'(i);
         if (!found && elig[idx]) begin
            found     = 1'b1;
            pick_leaf = idx;
         end
      end
      pick_len = 3'(want[pick_leaf]);
   end

   // Accept and pop in the same cycle net to len-1; a pop of an empty count is dropped
   always_comb begin
      res_sum = '0;
      for (int k = 0; k < NUM_LEAVES; k++) begin
         res_sum = reserved[k] + ((hs && (LEAF_W'(k) == o_req_leaf)) ? CNT_W'(o_req_len) : '0);
         res_nxt[k] = (i_leaf_deq[k] && (res_sum != '0)) ? res_sum - CNT_W'(1) : res_sum;
      end
      out_sum = outstanding + (hs ? OUT_W'(o_req_len) : '0);
      err_set = i_rsp_valid && (out_sum == '0);
      out_nxt = (i_rsp_valid && (out_sum != '0)) ? out_sum - OUT_W'(1) : out_sum;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = (i_run_lines == '0) ? S_DRAIN : S_PICK;
         S_PICK:  if (found) state_nxt = S_REQ;
                  else if (!any_rem) state_nxt = S_DRAIN;
         S_REQ:   if (i_req_ready) state_nxt = rem_left ? S_PICK : S_DRAIN;
         S_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_req_valid = (state == S_REQ);
      o_busy      = (state != S_IDLE);
      o_done      = (state == S_DONE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_LEAVES; k++) begin
            remaining[k] <= '0;
            next_addr[k] <= '0;
            reserved[k]  <= '0;
         end
         outstanding <= '0;
         rr_ptr      <= '0;
         o_req_addr  <= '0;
         o_req_len   <= '0;
         o_req_leaf  <= '0;
         o_err       <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_LEAVES; k++) begin
            reserved[k] <= res_nxt[k];
            if (start_acc) begin
               remaining[k] <= i_run_lines;
               next_addr[k] <= i_run_base + ADDR_W'(i_run_lines) * ADDR_W'(k);
            end else if (hs && (LEAF_W'(k) == o_req_leaf)) begin
               remaining[k] <= remaining[k] - LINES_W'(o_req_len);
               next_addr[k] <= next_addr[k] + ADDR_W'(o_req_len);
            end
         end
         outstanding <= out_nxt;
         if (err_set) o_err <= 1'b1;
         if (hs) rr_ptr <= o_req_leaf + LEAF_W'(1);
         if ((state == S_PICK) && found) begin
            o_req_leaf <= pick_leaf;
            o_req_addr <= next_addr[pick_leaf];
            o_req_len  <= pick_len;
         end
      end
   end

endmodule

// File: tb/tb_merge_leaf_refill_scheduler.sv
// Directed bench for merge_leaf_refill_scheduler: request order, back-pressure, tails, accounting, errors, reset.
module tb_merge_leaf_refill_scheduler;
   logic        i_clk = 1'b0;
   logic        i_rst, i_start, i_req_ready, i_rsp_valid;
   logic [31:0] i_run_base;
   logic [15:0] i_run_lines;
   logic [7:0]  i_leaf_deq;
   logic        o_req_valid, o_busy, o_done, o_err;
   logic [31:0] o_req_addr;
   logic [2:0]  o_req_len;
   logic [2:0]  o_req_leaf;

   merge_leaf_refill_scheduler dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_run_base(i_run_base),
      .i_run_lines(i_run_lines), .o_req_valid(o_req_valid), .o_req_addr(o_req_addr),
      .o_req_len(o_req_len), .o_req_leaf(o_req_leaf), .i_req_ready(i_req_ready),
      .i_rsp_valid(i_rsp_valid), .i_leaf_deq(i_leaf_deq), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err));

   always #5 i_clk = ~i_clk;

   int checks = 0, errors = 0;
   int req_n, done_cnt, pending, dly0, dly1, dly2;
   bit rsp_auto;
   logic [31:0] log_addr [128];
   int          log_len  [128];
   int          log_leaf [128];

   // One clock step: log handshakes, count done pulses, feed responses ~3 cycles after a request
   task automatic cycle();
      bit hs;
      int l;
      hs = o_req_valid && i_req_ready;
      l  = hs ? int'(o_req_len) : 0;
      if (hs) begin
         if (req_n < 128) begin
            log_addr[req_n] = o_req_addr;
            log_len[req_n]  = int'(o_req_len);
            log_leaf[req_n] = int'(o_req_leaf);
         end
         req_n++;
      end
      @(posedge i_clk); #1;
      if (o_done) done_cnt++;
      if (rsp_auto) begin
         pending += dly2;
         dly2 = dly1; dly1 = dly0; dly0 = l;
         if (pending > 0) begin i_rsp_valid = 1'b1; pending--; end
         else i_rsp_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_start = 1'b0; i_req_ready = 1'b0; i_rsp_valid = 1'b0;
      i_run_base = '0; i_run_lines = '0; i_leaf_deq = '0;
      rsp_auto = 0; req_n = 0; done_cnt = 0; pending = 0; dly0 = 0; dly1 = 0; dly2 = 0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
   endtask

   task automatic start(input logic [31:0] base, input logic [15:0] lines);
      i_run_base = base; i_run_lines = lines; i_start = 1'b1;
      cycle();
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin cycle(); n++; end
      checks++;
      if (done_cnt == 0) begin errors++; $display("FAIL %s_done_timeout: got no o_done, want one within %0d cycles", name, budget); end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({o_req_valid, o_busy, o_done, o_err} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b, want 0000", {o_req_valid, o_busy, o_done, o_err});
      end
      checks++;
      if (o_req_addr !== 32'd0 || o_req_len !== 3'd0 || o_req_leaf !== 3'd0) begin
         errors++; $display("FAIL reset_fields: got addr %h len %0d leaf %0d, want 0", o_req_addr, o_req_len, o_req_leaf);
      end
      checks++;
      if (dut.outstanding !== 8'd0 || dut.rr_ptr !== 3'd0) begin
         errors++; $display("FAIL reset_counters: got out %0d rr %0d, want 0 0", dut.outstanding, dut.rr_ptr);
      end
   endtask

   // Assumes the DUT was just reset
   task automatic run_basic(input string name);
      int leaf;
      logic [31:0] ea;
      i_req_ready = 1'b1; rsp_auto = 1;
      start(32'h100, 16'd8);
      wait_done(600, name);
      repeat (3) cycle();
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count: got %0d, want 1", name, done_cnt); end
      checks++;
      if (req_n != 16) begin errors++; $display("FAIL %s_req_count: got %0d, want 16", name, req_n); end
      for (int i = 0; i < 16 && i < req_n; i++) begin
         leaf = i % 8;
         ea = 32'h100 + 32'(leaf * 8) + 32'((i / 8) * 4);
         checks++;
         if (log_leaf[i] != leaf || log_addr[i] !== ea || log_len[i] != 4) begin
            errors++;
            $display("FAIL %s_req%0d: got leaf %0d addr %h len %0d, want leaf %0d addr %h len 4",
                     name, i, log_leaf[i], log_addr[i], log_len[i], leaf, ea);
         end
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (dut.reserved[k] !== 5'd8) begin errors++; $display("FAIL %s_reserved%0d: got %0d, want 8", name, k, dut.reserved[k]); end
      end
      checks++;
      if (dut.outstanding !== 8'd0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
         errors++; $display("FAIL %s_end_state: got out %0d busy %b err %b, want 0 0 0", name, dut.outstanding, o_busy, o_err);
      end
   endtask

   task automatic test_basic_run();
      do_reset();
      run_basic("basic");
   endtask

   task automatic test_back_pressure();
      int n0 = 0, n = 0;
      do_reset();
      i_req_ready = 1'b1; rsp_auto = 1;
      start(32'h2000, 16'd20);
      repeat (200) cycle();
      for (int i = 0; i < 32 && i < req_n; i++) if (log_leaf[i] == 0) n0++;
      checks++;
      if (req_n != 32 || n0 != 4) begin errors++; $display("FAIL bp_stall: got %0d reqs (%0d leaf0), want 32 (4)", req_n, n0); end
      checks++;
      if (dut.reserved[0] !== 5'd16 || o_busy !== 1'b1 || o_req_valid !== 1'b0) begin
         errors++; $display("FAIL bp_blocked: got res0 %0d busy %b valid %b, want 16 1 0", dut.reserved[0], o_busy, o_req_valid);
      end
      i_leaf_deq = 8'h01;
      repeat (4) cycle();
      i_leaf_deq = 8'h00;
      while (req_n < 33 && n < 20) begin cycle(); n++; end
      checks++;
      if (req_n != 33) begin errors++; $display("FAIL bp_resume_timeout: got %0d reqs, want 33", req_n); end
      else begin
         checks++;
         if (log_leaf[32] != 0 || log_addr[32] !== 32'h2010 || log_len[32] != 4) begin
            errors++; $display("FAIL bp_resume_req: got leaf %0d addr %h len %0d, want leaf 0 addr 2010 len 4",
                                log_leaf[32], log_addr[32], log_len[32]);
         end
         checks++;
         if (dut.reserved[0] !== 5'd16) begin errors++; $display("FAIL bp_resume_res: got %0d, want 16", dut.reserved[0]); end
      end
   endtask

   task automatic test_short_tail();
      int n = 0, el, ea, en;
      bit moved = 0;
      do_reset();
      rsp_auto = 1;
      start(32'h0, 16'd6);
      while (!o_req_valid && n < 10) begin cycle(); n++; end
      checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== 32'd0 || o_req_len !== 3'd4 || o_req_leaf !== 3'd0) begin
         errors++; $display("FAIL tail_first_req: got valid %b addr %h len %0d leaf %0d, want 1 0 4 0",
                             o_req_valid, o_req_addr, o_req_len, o_req_leaf);
      end
      repeat (5) begin
         cycle();
         if (o_req_valid !== 1'b1 || o_req_addr !== 32'd0 || o_req_len !== 3'd4 || o_req_leaf !== 3'd0) moved = 1;
      end
      checks++;
      if (moved) begin errors++; $display("FAIL tail_hold: got request change during stall, want stable 1 0 4 0"); end
      i_req_ready = 1'b1;
      wait_done(600, "tail");
      checks++;
      if (req_n != 16) begin errors++; $display("FAIL tail_req_count: got %0d, want 16", req_n); end
      for (int i = 0; i < 16 && i < req_n; i++) begin
         el = i % 8;
         ea = el * 6 + ((i < 8) ? 0 : 4);
         en = (i < 8) ? 4 : 2;
         checks++;
         if (log_leaf[i] != el || log_addr[i] !== 32'(ea) || log_len[i] != en) begin
            errors++; $display("FAIL tail_req%0d: got leaf %0d addr %h len %0d, want leaf %0d addr %h len %0d",
                                i, log_leaf[i], log_addr[i], log_len[i], el, ea, en);
         end
      end
      checks++;
      if (dut.reserved[3] !== 5'd6) begin errors++; $display("FAIL tail_reserved3: got %0d, want 6", dut.reserved[3]); end
   endtask

   task automatic test_same_cycle();
      int n = 0;
      do_reset();
      i_req_ready = 1'b1;
      start(32'h0, 16'd4);
      while (!(o_req_valid && o_req_leaf == 3'd2) && n < 20) begin cycle(); n++; end
      i_leaf_deq = 8'h04; i_rsp_valid = 1'b1;
      cycle();
      i_leaf_deq = 8'h00; i_rsp_valid = 1'b0;
      checks++;
      if (dut.reserved[2] !== 5'd3) begin errors++; $display("FAIL same_reserved2: got %0d, want 3", dut.reserved[2]); end
      checks++;
      if (dut.outstanding !== 8'd11) begin errors++; $display("FAIL same_outstanding: got %0d, want 11", dut.outstanding); end
      checks++;
      if (dut.reserved[0] !== 5'd4 || o_err !== 1'b0) begin
         errors++; $display("FAIL same_others: got res0 %0d err %b, want 4 0", dut.reserved[0], o_err);
      end
   endtask

   task automatic test_err_edge();
      int n = 0;
      do_reset();
      i_rsp_valid = 1'b1;
      cycle();
      i_rsp_valid = 1'b0;
      checks++;
      if (o_err !== 1'b1 || dut.outstanding !== 8'd0) begin
         errors++; $display("FAIL err_set: got err %b out %0d, want 1 0", o_err, dut.outstanding);
      end
      repeat (2) cycle();
      checks++;
      if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, want 1", o_err); end
      i_req_ready = 1'b1;
      start(32'h40, 16'd0);
      n = 1;
      while (done_cnt == 0 && n < 3) begin cycle(); n++; end
      checks++;
      if (done_cnt != 1 || req_n != 0) begin
         errors++; $display("FAIL zero_lines: got done %0d reqs %0d, want 1 0", done_cnt, req_n);
      end
      checks++;
      if (o_err !== 1'b1) begin errors++; $display("FAIL err_after_start: got %b, want 1", o_err); end
   endtask

   task automatic test_start_ignored();
      int n = 0;
      do_reset();
      i_req_ready = 1'b1; rsp_auto = 1;
      start(32'h0, 16'd4);
      i_start = 1'b1; i_run_base = 32'h5000; i_run_lines = 16'd9;
      while (done_cnt == 0 && n < 300) begin cycle(); n++; end
      i_start = 1'b0;
      repeat (3) cycle();
      checks++;
      if (req_n != 8 || done_cnt != 1) begin
         errors++; $display("FAIL restart_ignored: got %0d reqs %0d dones, want 8 1", req_n, done_cnt);
      end
      checks++;
      if (req_n >= 8 && (log_addr[7] !== 32'd28 || log_leaf[7] != 7 || log_len[7] != 4)) begin
         errors++; $display("FAIL restart_last_req: got addr %h leaf %0d len %0d, want 1c 7 4", log_addr[7], log_leaf[7], log_len[7]);
      end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL restart_idle: got busy %b, want 0", o_busy); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_reset();
      start(32'h100, 16'd8);
      while (!o_req_valid && n < 10) begin cycle(); n++; end
      i_rst = 1'b1;
      #1;
      checks++;
      if ({o_req_valid, o_busy, o_done} !== 3'b000 || dut.outstanding !== 8'd0) begin
         errors++; $display("FAIL reset_mid: got valid/busy/done %b out %0d, want 000 0", {o_req_valid, o_busy, o_done}, dut.outstanding);
      end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      req_n = 0; done_cnt = 0;
      run_basic("after_reset");
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_back_pressure();
      test_short_tail();
      test_same_cycle();
      test_err_edge();
      test_start_ignored();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/merge_leaf_refill_scheduler.md
Name: merge_leaf_refill_scheduler

Overview:
- Schedules line-granular read bursts from external memory into the NUM_LEAVES leaf input FIFOs of a merge tree of MERGER_16-style 2-to-1 mergers.
- Shares the single memory read-request port among leaves, round-robin.
- Issues a burst for a leaf only when that leaf's FIFO has guaranteed room for it.
- Tracks outstanding lines and signals completion once every leaf run is fully fetched and returned.

Parameters:
NUM_LEAVES, 8, number of leaf FIFOs (power of 2)
LEAF_W, 3, log2(NUM_LEAVES)
FIFO_DEPTH, 16, entries per leaf FIFO
CNT_W, 5, width of per-leaf reservation counter (holds 0..FIFO_DEPTH)
BURST_LEN, 4, maximum lines per request (must be ≤ FIFO_DEPTH)
ADDR_W, 32, line-address width
LINES_W, 16, width of run length in lines
OUT_W, 8, width of global outstanding-line counter

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  one-cycle start pulse; sampled only in IDLE
i_run_base  in  ADDR_W  line address of leaf 0's run, latched on start
i_run_lines  in  LINES_W  lines per leaf run, same for all leaves, latched on start
o_req_valid  out  1  read request valid
o_req_addr  out  ADDR_W  request start line address
o_req_len  out  3  lines in request, 1..BURST_LEN
o_req_leaf  out  LEAF_W  destination leaf
i_req_ready  in  1  memory accepts request when high together with o_req_valid
i_rsp_valid  in  1  one returned line, written to its leaf FIFO externally
i_leaf_deq  in  NUM_LEAVES  per-leaf pop strobe from the merge tree
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle completion pulse
o_err  out  1  sticky: response arrived with zero lines outstanding

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; reserved[k]=0; remaining[k]=0; outstanding=0.
- Reset mid-operation aborts immediately, including a pending request.
- Per-leaf state:
  - remaining[k]: lines still to request.
  - next_addr[k]: next line address; leaf k starts at i_run_base + k*i_run_lines.
  - reserved[k]: FIFO occupancy plus in-flight lines.
  - reserved[k] is NOT cleared on start; it only tracks request accepts and i_leaf_deq.
- Reservation accounting:
  - A request handshake for leaf k adds o_req_len to reserved[k].
  - i_leaf_deq[k] subtracts 1.
  - Both in the same cycle: net += len-1.
  - i_leaf_deq[k] with reserved[k]==0 is ignored (counter saturates at 0).
- Eligibility: leaf k is eligible when remaining[k]>0 and FIFO_DEPTH-reserved[k] ≥ min(BURST_LEN, remaining[k]).
- FSM states: IDLE, PICK, REQ, DRAIN, DONE.
  - IDLE: on i_start, latch config, set remaining[k]=i_run_lines for all k. Go to DRAIN if i_run_lines==0, else PICK.
  - PICK: search leaves rr_ptr, rr_ptr+1, … (mod NUM_LEAVES) for the first eligible one. If found, register o_req_addr/len/leaf, assert o_req_valid, go to REQ. If all remaining are 0, go to DRAIN. Otherwise stay in PICK.
  - REQ: o_req_valid and all request fields stay stable until i_req_ready. On handshake:
    - remaining[k] -= len; next_addr[k] += len; outstanding += len.
    - rr_ptr = k+1 mod NUM_LEAVES; o_req_valid=0.
    - Next state is DRAIN if this was the last remaining line of the last leaf, else PICK.
    - Minimum request-to-request spacing is 2 cycles.
  - DRAIN: wait until outstanding==0, then go to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- Outstanding counter:
  - Each i_rsp_valid decrements outstanding, in any state.
  - A handshake and a response in the same cycle give net += len-1.
  - i_rsp_valid with outstanding==0: o_err is set and stays 1 until reset; the counter does not underflow.
- Addresses wrap modulo 2^ADDR_W. o_req_len = min(BURST_LEN, remaining[k]), so the final burst of a leaf may be short.
- i_start outside IDLE is ignored.

Test Plan:
- Basic run: NUM_LEAVES=8, base=0x100, lines=8, ready always 1, responses 3 cycles after each request, deq tied 0 → requests in order leaf0@0x100 len4, leaf1@0x108 len4, …, leaf7@0x138, then second pass at 0x104, 0x10C, …; 16 requests total; o_done pulses once after the 64th response; every reserved[k] ends at 8.
- Back-pressure: with lines=20 and no deq, after 16 lines reach leaf 0 it is no longer requested (reserved=16) while other leaves proceed. Popping 4 from leaf 0 re-enables it, and its next request is @base+16 len4.
- Short tail and REQ hold: lines=6 → each leaf gets len4 then len2. Holding i_req_ready=0 for 5 cycles keeps o_req_valid/addr/len/leaf constant.
- Same-cycle events: accept a len4 request for leaf 2 in the same cycle as i_leaf_deq[2] and an i_rsp_valid → reserved[2] +3, outstanding +3.
- Error and edge cases:
  - i_rsp_valid in IDLE → o_err=1 and sticky; outstanding stays 0.
  - lines=0 start → o_done pulses within 3 cycles with no request.
  - i_start during PICK/REQ is ignored.
- Reset mid-burst: assert i_rst while in REQ → o_req_valid, o_busy, and o_done drop to 0 immediately. A fresh start afterwards behaves like the basic-run scenario.
